player_sprite_renderer: RTL and testbench

- Upstream companion of the player sprite ROM. Takes the VGA scan position (DrawX/DrawY) and the player position, and generates the ROM read address.
- Pipelines the hit/valid flag to match the ROM's 1-cycle registered read, then emits a colour and a foreground flag to the colour mapper.
- Latches player position once per frame so the sprite never tears mid-frame.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/player_sprite_renderer_if.sv | 28 ++
 rtl/sprite_hit_calc.sv | 64 ++++++
 rtl/player_sprite_renderer.sv | 100 ++++++++++
 tb/tb_player_sprite_renderer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the player sprite datapath.
// Optional mirroring is enabled with the PLAYER_MIRROR_EN macro (see player_sprite_renderer).
package sprite_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ROM_AW   = 19;

  typedef logic [23:0] rgb_t;
  typedef logic [9:0]  coord_t;

  // A ROM word is drawn only when it differs from the transparent key colour.
  function automatic logic is_opaque(input rgb_t colour, input rgb_t transp);
    return (colour != transp);
  endfunction

endpackage

// File: rtl/player_sprite_renderer_if.sv
// Scan/position/ROM bundle between the video timing side and the sprite renderer.
// master = the side that drives scan position, player state and ROM data.
// slave  = the renderer itself.
interface player_sprite_renderer_if;
  import sprite_pkg::*;

  logic                frame_start;
  coord_t              player_x;
  coord_t              player_y;
  logic                facing_left;
  coord_t              DrawX;
  coord_t              DrawY;
  logic [ROM_AW-1:0]   read_address;
  rgb_t                rom_data;
  rgb_t                pixel_rgb;
  logic                is_sprite;

  modport master (
    output frame_start, player_x, player_y, facing_left, DrawX, DrawY, rom_data,
    input  read_address, pixel_rgb, is_sprite
  );

  modport slave (
    input  frame_start, player_x, player_y, facing_left, DrawX, DrawY, rom_data,
    output read_address, pixel_rgb, is_sprite
  );

endinterface

// File: rtl/sprite_hit_calc.sv
// Combinational hit test and ROM address generation for one scan pixel.
// With PLAYER_MIRROR_EN defined, flip=1 reverses the column inside the sprite row.
module sprite_hit_calc
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W     = 16,
  parameter int unsigned SPR_H     = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  coord_t            draw_x,
  input  coord_t            draw_y,
  input  coord_t            sx,
  input  coord_t            sy,
  input  logic              flip,
  output logic              hit,
  output logic [ROM_AW-1:0] addr
);

  localparam logic [10:0]       SPR_W11   = 11'(SPR_W);
  localparam logic [10:0]       SPR_H11   = 11'(SPR_H);
  localparam logic [10:0]       COL_MAX11 = 11'(SPR_W - 1);
  localparam logic [ROM_AW-1:0] BASE_AW   = ROM_AW'(BASE_ADDR);
  localparam logic [ROM_AW-1:0] STRIDE_AW = ROM_AW'(SPR_W);

  logic [10:0] rel_x_s;
  logic [10:0] rel_y_s;
  logic [10:0] col_s;
  logic        borrow_s;

  // 11-bit offsets so a sprite hanging past the right edge cannot alias onto column 0.
  assign rel_x_s  = {1'b0, draw_x} - {1'b0, sx};
  assign rel_y_s  = {1'b0, draw_y} - {1'b0, sy};
  assign borrow_s = (draw_x < sx) || (draw_y < sy);
  assign hit      = (!borrow_s) && (rel_x_s < SPR_W11) && (rel_y_s < SPR_H11);

`ifdef PLAYER_MIRROR_EN
  // Column select: mirrored when the player faces left.
  always_comb begin
    col_s = rel_x_s;
    if (flip) begin
      col_s = COL_MAX11 - rel_x_s;
    end else begin
      col_s = rel_x_s;
    end
  end
`else
  logic unused_flip_s;
  logic [10:0] unused_colmax_s;
  assign unused_flip_s   = flip;
  assign unused_colmax_s = COL_MAX11;
  assign col_s           = rel_x_s;
`endif

  // Row-major address inside the sprite; off-sprite pixels point at the first word.
  always_comb begin
    addr = BASE_AW;
    if (hit) begin
      addr = BASE_AW + (ROM_AW'(rel_y_s) * STRIDE_AW) + ROM_AW'(col_s);
    end else begin
      addr = BASE_AW;
    end
  end

endmodule

// File: rtl/player_sprite_renderer.sv
// Player sprite renderer: frame-latched player position, ROM address stage,
// and colour/foreground stage aligned to the ROM's one-cycle read.
// Optional macro PLAYER_MIRROR_EN: honour facing_left by mirroring sprite columns.
module player_sprite_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = 16,
  parameter int unsigned SPR_H      = 16,
  parameter int unsigned BASE_ADDR  = 0,
  parameter rgb_t        TRANSP_RGB = 24'h000000
) (
  input logic                      Clk,
  input logic                      Reset_n,
  player_sprite_renderer_if.slave  bus
);

  coord_t            sx_r;
  coord_t            sy_r;
  logic              flip_s;
  logic              hit_s;
  logic [ROM_AW-1:0] addr_s;
  logic [ROM_AW-1:0] read_address_r;
  logic              hit_q1_r;
  rgb_t              pixel_rgb_r;
  logic              is_sprite_r;

  // Shadow position: only updated at frame start so the sprite cannot tear mid-frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx_r <= 10'd0;
      sy_r <= 10'd0;
    end else if (bus.frame_start) begin
      sx_r <= bus.player_x;
      sy_r <= bus.player_y;
    end
  end

`ifdef PLAYER_MIRROR_EN
  logic face_r;

  // Shadow facing, latched alongside the position.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      face_r <= 1'b0;
    end else if (bus.frame_start) begin
      face_r <= bus.facing_left;
    end
  end

  assign flip_s = face_r;
`else
  logic unused_facing_s;
  assign unused_facing_s = bus.facing_left;
  assign flip_s          = 1'b0;
`endif

  sprite_hit_calc #(
    .SPR_W     (SPR_W),
    .SPR_H     (SPR_H),
    .BASE_ADDR (BASE_ADDR)
  ) u_hit_calc (
    .draw_x (bus.DrawX),
    .draw_y (bus.DrawY),
    .sx     (sx_r),
    .sy     (sy_r),
    .flip   (flip_s),
    .hit    (hit_s),
    .addr   (addr_s)
  );

  // Stage 1: register the ROM address and carry the hit flag alongside it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address_r <= {ROM_AW{1'b0}};
      hit_q1_r       <= 1'b0;
    end else begin
      read_address_r <= addr_s;
      hit_q1_r       <= hit_s;
    end
  end

  // Stage 2: combine the delayed hit with the returned ROM colour.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_sprite_r <= 1'b0;
      pixel_rgb_r <= 24'h000000;
    end else if (hit_q1_r && is_opaque(bus.rom_data, TRANSP_RGB)) begin
      is_sprite_r <= 1'b1;
      pixel_rgb_r <= bus.rom_data;
    end else begin
      is_sprite_r <= 1'b0;
      pixel_rgb_r <= 24'h000000;
    end
  end

  assign bus.read_address = read_address_r;
  assign bus.is_sprite    = is_sprite_r;
  assign bus.pixel_rgb    = pixel_rgb_r;

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Self-checking bench for player_sprite_renderer with a behavioural sprite model.
module tb_player_sprite_renderer;

  localparam int SW = 16;
  localparam int SH = 16;

  logic Clk;
  logic Reset_n;

  player_sprite_renderer_if bus ();

  player_sprite_renderer dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference state: shadow position/facing and pending stage-2 expectation.
  int          m_sx, m_sy;
  bit          m_face;
  bit          pend_spr;
  logic [23:0] pend_rgb;
  logic [23:0] rom_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sprite rule from scratch: box test on the frame-latched position, row-major index.
  task automatic model(input int x, input int y, output bit h, output int a);
    int col;
    h = (x >= m_sx) && (x < m_sx + SW) && (y >= m_sy) && (y < m_sy + SH);
    col = x - m_sx;
`ifdef PLAYER_MIRROR_EN
    if (m_face) col = SW - 1 - col;
`endif
    a = h ? ((y - m_sy) * SW + col) : 0;
  endtask

  // One scan pixel: drive, advance a clock, check both pipeline stages, feed ROM.
  task automatic cyc(input int x, input int y, input bit fs, input int px, input int py,
                     input bit face, input int ovr);
    bit          eh;
    int          ea;
    logic [23:0] v;
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.frame_start = fs;
    bus.player_x    = 10'(px);
    bus.player_y    = 10'(py);
    bus.facing_left = face;
    model(x, y, eh, ea);
    if (fs) begin
      m_sx   = px;
      m_sy   = py;
      m_face = face;
    end
    @(posedge Clk);
    #1;
    chk("read_address", 32'(bus.read_address), 32'(ea));
    chk("is_sprite", 32'(bus.is_sprite), 32'(pend_spr));
    chk("pixel_rgb", 32'(bus.pixel_rgb), 32'(pend_rgb));
    v = (ovr >= 0) ? 24'(ovr) : rom_mem[ea & 255];
    bus.rom_data = v;
    pend_spr = eh && (v != 24'h000000);
    pend_rgb = pend_spr ? v : 24'h000000;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, 32'(bus.read_address), 32'd0);
    chk({tag, "_spr"},  32'(bus.is_sprite), 32'd0);
    chk({tag, "_rgb"},  32'(bus.pixel_rgb), 32'd0);
  endtask

  initial begin
    int px, py, x, y;
    for (int i = 0; i < 256; i++) begin
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 24'h000000 : 24'($urandom | 1);
    end
    Reset_n         = 1'b0;
    bus.frame_start = 1'b0;
    bus.player_x    = 10'd0;
    bus.player_y    = 10'd0;
    bus.facing_left = 1'b0;
    bus.DrawX       = 10'd0;
    bus.DrawY       = 10'd0;
    bus.rom_data    = 24'h000000;
    m_sx = 0; m_sy = 0; m_face = 1'b0;
    pend_spr = 1'b0; pend_rgb = 24'h000000;

    repeat (2) @(posedge Clk);
    #1;
    chk_zero("reset");
    Reset_n = 1'b1;

    // Scan with a real frame latch, then reset mid-scan.
    cyc(0, 0, 1'b1, 200, 100, 1'b0, -1);
    cyc(205, 105, 1'b0, 200, 100, 1'b0, -1);
    cyc(206, 105, 1'b0, 200, 100, 1'b0, 24'h123456);
    cyc(207, 105, 1'b0, 200, 100, 1'b0, -1);
    Reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    m_sx = 0; m_sy = 0; m_face = 1'b0;
    pend_spr = 1'b0; pend_rgb = 24'h000000;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // No frame_start since reset: shadow sits at (0,0).
    for (int i = 0; i < 18; i++) cyc(i, 0, 1'b0, 300, 300, 1'b0, -1);
    for (int i = 14; i < 18; i++) cyc(i, 15, 1'b0, 300, 300, 1'b0, -1);
    for (int i = 0; i < 3; i++) cyc(i, 16, 1'b0, 300, 300, 1'b0, -1);

    // Latch (100,50) and probe corners and just outside.
    cyc(0, 0, 1'b1, 100, 50, 1'b0, -1);
    cyc(100, 50, 1'b0, 100, 50, 1'b0, 24'hA5A5A5);
    cyc(115, 65, 1'b0, 100, 50, 1'b0, 24'h00FF00);
    cyc(116, 65, 1'b0, 100, 50, 1'b0, 24'h0000FF);
    cyc(99, 50, 1'b0, 100, 50, 1'b0, 24'h0000FF);
    cyc(100, 49, 1'b0, 100, 50, 1'b0, 24'h0000FF);

    // Transparency key inside the box.
    cyc(105, 55, 1'b0, 100, 50, 1'b0, 24'h000000);
    cyc(106, 55, 1'b0, 100, 50, 1'b0, 24'hFFFFFF);
    cyc(107, 55, 1'b0, 100, 50, 1'b0, -1);

    // Shadow timing: player_x moves without frame_start.
    cyc(100, 50, 1'b0, 300, 50, 1'b0, -1);
    cyc(300, 50, 1'b0, 300, 50, 1'b0, -1);
    cyc(110, 52, 1'b1, 300, 50, 1'b0, -1);
    cyc(110, 52, 1'b0, 300, 50, 1'b0, -1);
    cyc(305, 52, 1'b0, 300, 50, 1'b0, -1);

    // Right/bottom edge: no wrap to column 0.
    cyc(0, 0, 1'b1, 632, 470, 1'b0, -1);
    cyc(639, 470, 1'b0, 632, 470, 1'b0, -1);
    cyc(0, 470, 1'b0, 632, 470, 1'b0, -1);
    cyc(7, 471, 1'b0, 632, 470, 1'b0, -1);
    cyc(639, 485, 1'b0, 632, 470, 1'b0, -1);
    cyc(639, 486, 1'b0, 632, 470, 1'b0, -1);

    // Player off the visible area.
    cyc(0, 0, 1'b1, 700, 10, 1'b0, -1);
    for (int i = 0; i < 12; i++) cyc($urandom_range(0, 639), $urandom_range(0, 30), 1'b0, 700, 10, 1'b0, -1);

    // Mirroring (address depends on build option).
    cyc(0, 0, 1'b1, 100, 50, 1'b1, -1);
    cyc(100, 50, 1'b0, 100, 50, 1'b1, -1);
    cyc(101, 50, 1'b0, 100, 50, 1'b1, -1);
    cyc(115, 60, 1'b0, 100, 50, 1'b1, -1);

    // Randomised scan around the sprite with occasional frame latches.
    px = 100; py = 50;
    for (int i = 0; i < 300; i++) begin
      bit fs;
      fs = ($urandom_range(0, 29) == 0);
      if (fs) begin
        px = $urandom_range(0, 660);
        py = $urandom_range(0, 490);
      end
      if (m_sx <= 639) begin
        x = m_sx - 4 + $urandom_range(0, 23);
        y = m_sy - 4 + $urandom_range(0, 23);
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
      end else begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
      end
      cyc(x, y, fs, px, py, 1'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
